// File: rtl/step_calc_scheduler_pkg.sv
// Shared types and constants for the silencer step-calculator scheduler.
package step_calc_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, START, FEED, DRAIN} sched_state_t;

   localparam int unsigned STEP_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 9;
   localparam int unsigned OVR_W  = 8;

   localparam logic [STEP_W-1:0] DEF_STEP_INT = STEP_W'(10);
   localparam logic [STEP_W-1:0] DEF_STEP_PHS = STEP_W'(40);

   // A zero step count would divide by zero downstream; store it as 1.
   function automatic logic [STEP_W-1:0] clamp_step(input logic [STEP_W-1:0] v);
      return (v == '0) ? STEP_W'(1) : v;
   endfunction

endpackage

// File: rtl/step_calc_scheduler_beat_counter.sv
// Counts result beats of one step calculator; flags a full burst and any beat beyond it.
module step_calc_scheduler_beat_counter
   import step_calc_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 249
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic beat_i,
   output logic complete_o,
   output logic excess_o
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH + 1);

   logic [CNT_W-1:0] count_q;
   logic             complete_q;
   logic             excess_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         complete_q <= 1'b0;
         excess_q   <= 1'b0;
      end else begin
         excess_q <= 1'b0;
         if (clr_i) begin
            count_q    <= '0;
            complete_q <= 1'b0;
         end else if (beat_i) begin
            // Count saturates at a full burst; extra beats only raise the excess flag.
            if (count_q == FULL) begin
               excess_q <= 1'b1;
            end else begin
               count_q    <= count_q + CNT_W'(1);
               complete_q <= (count_q == FULL - CNT_W'(1));
            end
         end
      end
   end

   assign complete_o = complete_q;
   assign excess_o   = excess_q;

endmodule

// File: rtl/step_calc_scheduler.sv
// Sequences the intensity/phase step calculators for each drive-data update:
// start strobe, source-address sweep, then wait for both result bursts.
module step_calc_scheduler
   import step_calc_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH   = 249,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              update_req_i,
   input  logic              config_valid_i,
   input  logic [STEP_W-1:0] completion_steps_intensity_i,
   input  logic [STEP_W-1:0] completion_steps_phase_i,
   input  logic              err_clr_i,
   output logic              step_din_valid_o,
   output logic [STEP_W-1:0] step_completion_intensity_o,
   output logic [STEP_W-1:0] step_completion_phase_o,
   output logic [ADDR_W-1:0] src_addr_o,
   output logic              src_valid_o,
   input  logic              int_dout_valid_i,
   input  logic              phs_dout_valid_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [OVR_W-1:0]  overrun_cnt_o,
   output logic              err_o
);

   localparam int unsigned       TIMER_CLOG = $clog2(TIMEOUT + 1);
   localparam int unsigned       TIMER_W    = (TIMER_CLOG < 10) ? 10 : TIMER_CLOG;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH);

   sched_state_t       state_q;
   logic [STEP_W-1:0]  shadow_int_q, shadow_phs_q;
   logic [STEP_W-1:0]  act_int_q, act_phs_q;
   logic               pending_q;
   logic               din_valid_q;
   logic               src_valid_q;
   logic [ADDR_W-1:0]  src_addr_q;
   logic               busy_q;
   logic               done_q;
   logic [OVR_W-1:0]   overrun_q;
   logic               err_q;
   logic [TIMER_W-1:0] timer_q;

   logic int_cpl, phs_cpl, int_exc, phs_exc;
   logic busy_c, go_c, pass_done_c, timeout_c;

   assign busy_c      = (state_q != IDLE);
   assign go_c        = (state_q == IDLE) && (update_req_i || pending_q);
   assign pass_done_c = (state_q == DRAIN) && int_cpl && phs_cpl;
   assign timeout_c   = busy_c && (timer_q == TIMER_W'(TIMEOUT));

   step_calc_scheduler_beat_counter #(.DEPTH(DEPTH)) u_int_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (go_c),
      .beat_i     (int_dout_valid_i && busy_c),
      .complete_o (int_cpl),
      .excess_o   (int_exc)
   );

   step_calc_scheduler_beat_counter #(.DEPTH(DEPTH)) u_phs_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (go_c),
      .beat_i     (phs_dout_valid_i && busy_c),
      .complete_o (phs_cpl),
      .excess_o   (phs_exc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shadow_int_q <= DEF_STEP_INT;
         shadow_phs_q <= DEF_STEP_PHS;
         act_int_q    <= DEF_STEP_INT;
         act_phs_q    <= DEF_STEP_PHS;
         pending_q    <= 1'b0;
         din_valid_q  <= 1'b0;
         src_valid_q  <= 1'b0;
         src_addr_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= '0;
         err_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         din_valid_q <= 1'b0;
         done_q      <= 1'b0;

         if (config_valid_i) begin
            shadow_int_q <= clamp_step(completion_steps_intensity_i);
            shadow_phs_q <= clamp_step(completion_steps_phase_i);
         end

         // Requests during a pass collapse into one pending pass.
         if (update_req_i && busy_c) begin
            pending_q <= 1'b1;
            if (overrun_q != '1) overrun_q <= overrun_q + OVR_W'(1);
         end

         if (err_clr_i) err_q <= 1'b0;
         if (int_exc || phs_exc) err_q <= 1'b1;

         if (busy_c) timer_q <= timer_q + TIMER_W'(1);

         case (state_q)
            IDLE: begin
               if (go_c) begin
                  state_q     <= START;
                  pending_q   <= 1'b0;
                  din_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  act_int_q   <= shadow_int_q;
                  act_phs_q   <= shadow_phs_q;
                  timer_q     <= '0;
               end
            end
            START: begin
               state_q     <= FEED;
               src_valid_q <= 1'b1;
               src_addr_q  <= '0;
            end
            FEED: begin
               if (src_addr_q == LAST_ADDR) begin
                  state_q     <= DRAIN;
                  src_valid_q <= 1'b0;
                  src_addr_q  <= '0;
               end else begin
                  src_addr_q <= src_addr_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase

         // Completion takes priority over a timeout landing in the same cycle.
         if (pass_done_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end else if (timeout_c) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            src_valid_q <= 1'b0;
            src_addr_q  <= '0;
            err_q       <= 1'b1;
         end
      end
   end

   assign step_din_valid_o            = din_valid_q;
   assign step_completion_intensity_o = act_int_q;
   assign step_completion_phase_o     = act_phs_q;
   assign src_addr_o                  = src_addr_q;
   assign src_valid_o                 = src_valid_q;
   assign busy_o                      = busy_q;
   assign done_o                      = done_q;
   assign overrun_cnt_o               = overrun_q;
   assign err_o                       = err_q;

endmodule
